// File: rtl/mult_result_reducer_if.sv
// Handshake and data bundle between the product reducer, the multiplier read port and the controller.
// The slave modport is the reducer; the master modport is everything that talks to it.
interface mult_result_reducer_if #(
    parameter int LOGDEPTH = 6,
    parameter int WIDTH    = 32
);
    logic                      EN_reduce;
    logic                      RDY_reduce;
    logic                      EN_blockRead;
    logic                      VALID_memVal;
    logic [WIDTH-1:0]          memVal_data;
    logic                      VALID_result;
    logic                      EN_resultAck;
    logic [WIDTH+LOGDEPTH-1:0] result_sum;
    logic [WIDTH-1:0]          result_max;
    logic [WIDTH-1:0]          result_min;
    logic [LOGDEPTH:0]         result_count;
    logic                      result_err;

    modport master (
        output EN_reduce, VALID_memVal, memVal_data, EN_resultAck,
        input  RDY_reduce, EN_blockRead, VALID_result,
               result_sum, result_max, result_min, result_count, result_err
    );

    modport slave (
        input  EN_reduce, VALID_memVal, memVal_data, EN_resultAck,
        output RDY_reduce, EN_blockRead, VALID_result,
               result_sum, result_max, result_min, result_count, result_err
    );
endinterface

// File: rtl/mult_result_reducer.sv
// Requests a block read from the multiplier and reduces the product stream to sum/max/min/count,
// holding the result under a valid/ack handshake until the controller consumes it.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a start request
// REQ     | EN_blockRead high, waiting for the first product word
// COLLECT | accepting words until valid drops or the memory is full
// DONE    | result held and VALID_result high until acked
module mult_result_reducer #(
    parameter int LOGDEPTH = 6,
    parameter int WIDTH    = 32,
    parameter int TIMEOUT  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    mult_result_reducer_if.slave  bus
);
    localparam int          SW     = WIDTH + LOGDEPTH;
    localparam int          CW     = LOGDEPTH + 1;
    localparam int          TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned MAXCNT = 2 ** LOGDEPTH;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_COLLECT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]    sum_q, sum_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [WIDTH-1:0] min_q, min_d;
    logic [CW-1:0]    count_q, count_d;
    logic             err_q, err_d;
    logic             blk_q, blk_d;
    logic [TW-1:0]    tmo_q, tmo_d;

    logic start;
    logic accept;
    logic last_word;
    logic tmo_last;

    assign start     = (state_q == S_IDLE) && bus.EN_reduce;
    assign accept    = bus.VALID_memVal && ((state_q == S_REQ) || (state_q == S_COLLECT));
    assign last_word = accept && (count_q == CW'(MAXCNT - 1));
    assign tmo_last  = (tmo_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.EN_reduce) state_d = S_REQ;
            end
            S_REQ: begin
                // A word on the timeout cycle still wins over the abort.
                if (bus.VALID_memVal)  state_d = last_word ? S_DONE : S_COLLECT;
                else if (tmo_last)     state_d = S_DONE;
            end
            S_COLLECT: begin
                if (!bus.VALID_memVal || last_word) state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.EN_resultAck) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sum_d   = sum_q;
        max_d   = max_q;
        min_d   = min_q;
        count_d = count_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        blk_d   = (state_d == S_REQ);
        if (start) begin
            sum_d   = '0;
            max_d   = '0;
            min_d   = '1;
            count_d = '0;
            err_d   = 1'b0;
            tmo_d   = '0;
        end else begin
            if (accept) begin
                sum_d   = sum_q + {{LOGDEPTH{1'b0}}, bus.memVal_data};
                count_d = count_q + CW'(1);
                if (bus.memVal_data > max_q) max_d = bus.memVal_data;
                if (bus.memVal_data < min_q) min_d = bus.memVal_data;
            end
            if (state_q == S_REQ) begin
                tmo_d = tmo_q + TW'(1);
                if (!bus.VALID_memVal && tmo_last) err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            max_q   <= '0;
            min_q   <= '1;
            count_q <= '0;
            err_q   <= 1'b0;
            blk_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            sum_q   <= sum_d;
            max_q   <= max_d;
            min_q   <= min_d;
            count_q <= count_d;
            err_q   <= err_d;
            blk_q   <= blk_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.RDY_reduce   = (state_q == S_IDLE);
    assign bus.EN_blockRead = blk_q;
    assign bus.VALID_result = (state_q == S_DONE);
    assign bus.result_sum   = sum_q;
    assign bus.result_max   = max_q;
    assign bus.result_min   = min_q;
    assign bus.result_count = count_q;
    assign bus.result_err   = err_q;

endmodule

// File: tb/tb_mult_result_reducer.sv
// Directed bench for mult_result_reducer: stream, full-memory, timeout, hold/ack and mid-stream reset.
module tb_mult_result_reducer;
    localparam int L = 6;
    localparam int W = 32;
    localparam int T = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mult_result_reducer_if #(.LOGDEPTH(L), .WIDTH(W)) bus ();

    mult_result_reducer #(.LOGDEPTH(L), .WIDTH(W), .TIMEOUT(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_result();
        bus.EN_resultAck = 1'b1;
        bus.EN_reduce    = 1'b0;
        bus.VALID_memVal = 1'b0;
        step();
        bus.EN_resultAck = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (bus.RDY_reduce !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %0h expected 1", bus.RDY_reduce); end
        checks++; if (bus.EN_blockRead !== 1'b0) begin errors++; $display("FAIL reset_blk: got %0h expected 0", bus.EN_blockRead); end
        checks++; if (bus.VALID_result !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h expected 0", bus.VALID_result); end
        checks++; if (bus.result_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0h expected 0", bus.result_err); end
        checks++; if (bus.result_sum !== 38'd0) begin errors++; $display("FAIL reset_sum: got %0h expected 0", bus.result_sum); end
        checks++; if (bus.result_max !== 32'd0) begin errors++; $display("FAIL reset_max: got %0h expected 0", bus.result_max); end
        checks++; if (bus.result_min !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_min: got %0h expected ffffffff", bus.result_min); end
        checks++; if (bus.result_count !== 7'd0) begin errors++; $display("FAIL reset_count: got %0h expected 0", bus.result_count); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_stream_63();
        int blk_cycles;
        bit early_valid;
        blk_cycles  = 0;
        early_valid = 0;
        bus.EN_reduce = 1'b1;
        step();
        bus.EN_reduce = 1'b0;
        checks++; if (bus.RDY_reduce !== 1'b0) begin errors++; $display("FAIL start_rdy: got %0h expected 0", bus.RDY_reduce); end
        checks++; if (bus.EN_blockRead !== 1'b1) begin errors++; $display("FAIL start_blk: got %0h expected 1", bus.EN_blockRead); end
        for (int k = 1; k <= 63; k++) begin
            bus.VALID_memVal = 1'b1;
            bus.memVal_data  = W'(k * k);
            if (bus.EN_blockRead === 1'b1) blk_cycles++;
            step();
            if (bus.VALID_result === 1'b1) early_valid = 1;
        end
        bus.VALID_memVal = 1'b0;
        bus.memVal_data  = '0;
        step();
        checks++; if (early_valid) begin errors++; $display("FAIL s63_early_valid: got 1 expected 0"); end
        checks++; if (blk_cycles !== 1) begin errors++; $display("FAIL s63_blk_cycles: got %0d expected 1", blk_cycles); end
        checks++; if (bus.VALID_result !== 1'b1) begin errors++; $display("FAIL s63_valid: got %0h expected 1", bus.VALID_result); end
        checks++; if (bus.result_count !== 7'd63) begin errors++; $display("FAIL s63_count: got %0d expected 63", bus.result_count); end
        checks++; if (bus.result_sum !== 38'd85344) begin errors++; $display("FAIL s63_sum: got %0d expected 85344", bus.result_sum); end
        checks++; if (bus.result_max !== 32'd3969) begin errors++; $display("FAIL s63_max: got %0d expected 3969", bus.result_max); end
        checks++; if (bus.result_min !== 32'd1) begin errors++; $display("FAIL s63_min: got %0d expected 1", bus.result_min); end
        checks++; if (bus.result_err !== 1'b0) begin errors++; $display("FAIL s63_err: got %0h expected 0", bus.result_err); end
    endtask

    task automatic test_hold_ack();
        bit bad_hold;
        bad_hold = 0;
        for (int i = 0; i < 10; i++) begin
            bus.VALID_memVal = i[0];
            bus.EN_reduce    = ~i[0];
            bus.memVal_data  = W'(32'h5000_0000 + i);
            step();
            if (bus.VALID_result !== 1'b1 || bus.result_sum !== 38'd85344 || bus.result_count !== 7'd63 ||
                bus.result_max !== 32'd3969 || bus.result_min !== 32'd1 || bus.RDY_reduce !== 1'b0 ||
                bus.EN_blockRead !== 1'b0) bad_hold = 1;
        end
        checks++; if (bad_hold) begin errors++; $display("FAIL hold_stable: got changed expected stable"); end
        ack_result();
        checks++; if (bus.VALID_result !== 1'b0) begin errors++; $display("FAIL ack_valid: got %0h expected 0", bus.VALID_result); end
        checks++; if (bus.RDY_reduce !== 1'b1) begin errors++; $display("FAIL ack_rdy: got %0h expected 1", bus.RDY_reduce); end
    endtask

    task automatic test_max_count();
        bit early_valid;
        early_valid = 0;
        bus.EN_reduce = 1'b1;
        step();
        bus.EN_reduce = 1'b0;
        for (int i = 1; i <= 70; i++) begin
            bus.VALID_memVal = 1'b1;
            bus.memVal_data  = 32'hFFFF_FFFF;
            step();
            if (i < 64 && bus.VALID_result === 1'b1) early_valid = 1;
            if (i == 64) begin
                checks++; if (bus.VALID_result !== 1'b1) begin errors++; $display("FAIL full_valid64: got %0h expected 1", bus.VALID_result); end
                checks++; if (bus.result_count !== 7'd64) begin errors++; $display("FAIL full_count64: got %0d expected 64", bus.result_count); end
            end
        end
        bus.VALID_memVal = 1'b0;
        checks++; if (early_valid) begin errors++; $display("FAIL full_early_valid: got 1 expected 0"); end
        checks++; if (bus.result_count !== 7'd64) begin errors++; $display("FAIL full_count: got %0d expected 64", bus.result_count); end
        checks++; if (bus.result_sum !== 38'h3F_FFFF_FFC0) begin errors++; $display("FAIL full_sum: got %0h expected 3fffffffc0", bus.result_sum); end
        checks++; if (bus.result_max !== 32'hFFFF_FFFF || bus.result_min !== 32'hFFFF_FFFF) begin errors++; $display("FAIL full_maxmin: got %0h/%0h expected ffffffff/ffffffff", bus.result_max, bus.result_min); end
        checks++; if (bus.VALID_result !== 1'b1) begin errors++; $display("FAIL full_valid_hold: got %0h expected 1", bus.VALID_result); end
        ack_result();
    endtask

    task automatic test_timeout();
        int blk_cycles;
        int n;
        blk_cycles = 0;
        n = 0;
        bus.VALID_memVal = 1'b0;
        bus.EN_reduce = 1'b1;
        step();
        bus.EN_reduce = 1'b0;
        while (bus.VALID_result !== 1'b1 && n < 40) begin
            if (bus.EN_blockRead === 1'b1) blk_cycles++;
            step();
            n++;
        end
        checks++; if (bus.VALID_result !== 1'b1) begin errors++; $display("FAIL tmo_reached: got %0h expected 1 within 40 cycles", bus.VALID_result); end
        checks++; if (blk_cycles !== 16) begin errors++; $display("FAIL tmo_blk_cycles: got %0d expected 16", blk_cycles); end
        checks++; if (bus.result_err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %0h expected 1", bus.result_err); end
        checks++; if (bus.result_count !== 7'd0) begin errors++; $display("FAIL tmo_count: got %0d expected 0", bus.result_count); end
        checks++; if (bus.result_sum !== 38'd0) begin errors++; $display("FAIL tmo_sum: got %0h expected 0", bus.result_sum); end
        checks++; if (bus.result_min !== 32'hFFFF_FFFF) begin errors++; $display("FAIL tmo_min: got %0h expected ffffffff", bus.result_min); end
        checks++; if (bus.EN_blockRead !== 1'b0) begin errors++; $display("FAIL tmo_blk_low: got %0h expected 0", bus.EN_blockRead); end
        ack_result();
    endtask

    task automatic test_timeout_edge();
        bus.VALID_memVal = 1'b0;
        bus.EN_reduce = 1'b1;
        step();
        bus.EN_reduce = 1'b0;
        for (int i = 0; i < 15; i++) step();
        checks++; if (bus.EN_blockRead !== 1'b1) begin errors++; $display("FAIL edge_still_req: got %0h expected 1", bus.EN_blockRead); end
        bus.VALID_memVal = 1'b1;
        bus.memVal_data  = 32'd5;
        step();
        bus.VALID_memVal = 1'b0;
        step();
        checks++; if (bus.VALID_result !== 1'b1) begin errors++; $display("FAIL edge_valid: got %0h expected 1", bus.VALID_result); end
        checks++; if (bus.result_err !== 1'b0) begin errors++; $display("FAIL edge_err: got %0h expected 0", bus.result_err); end
        checks++; if (bus.result_count !== 7'd1) begin errors++; $display("FAIL edge_count: got %0d expected 1", bus.result_count); end
        checks++; if (bus.result_sum !== 38'd5 || bus.result_max !== 32'd5 || bus.result_min !== 32'd5) begin errors++; $display("FAIL edge_data: got %0d/%0d/%0d expected 5/5/5", bus.result_sum, bus.result_max, bus.result_min); end
        ack_result();
    endtask

    task automatic test_reset_midstream();
        bit saw_valid;
        saw_valid = 0;
        bus.EN_reduce = 1'b1;
        step();
        bus.EN_reduce = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            bus.VALID_memVal = 1'b1;
            bus.memVal_data  = W'(100 + k);
            step();
        end
        rst = 1'b1;
        step();
        checks++; if (bus.RDY_reduce !== 1'b1 || bus.EN_blockRead !== 1'b0 || bus.VALID_result !== 1'b0 || bus.result_err !== 1'b0) begin
            errors++; $display("FAIL rst_ctrl: got rdy=%0h blk=%0h vld=%0h err=%0h expected 1 0 0 0", bus.RDY_reduce, bus.EN_blockRead, bus.VALID_result, bus.result_err); end
        checks++; if (bus.result_sum !== 38'd0 || bus.result_count !== 7'd0) begin errors++; $display("FAIL rst_acc: got sum=%0h cnt=%0h expected 0 0", bus.result_sum, bus.result_count); end
        checks++; if (bus.result_max !== 32'd0 || bus.result_min !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_maxmin: got %0h/%0h expected 0/ffffffff", bus.result_max, bus.result_min); end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.VALID_memVal = i[0];
            step();
            if (bus.VALID_result === 1'b1 || bus.RDY_reduce !== 1'b1) saw_valid = 1;
        end
        checks++; if (saw_valid) begin errors++; $display("FAIL rst_no_result: got result/busy expected idle"); end
        bus.VALID_memVal = 1'b0;
        bus.EN_reduce = 1'b1;
        step();
        bus.EN_reduce = 1'b0;
        bus.VALID_memVal = 1'b1;
        bus.memVal_data = 32'd7; step();
        bus.memVal_data = 32'd2; step();
        bus.memVal_data = 32'd9; step();
        bus.VALID_memVal = 1'b0;
        step();
        checks++; if (bus.VALID_result !== 1'b1) begin errors++; $display("FAIL fresh_valid: got %0h expected 1", bus.VALID_result); end
        checks++; if (bus.result_count !== 7'd3 || bus.result_sum !== 38'd18) begin errors++; $display("FAIL fresh_cnt_sum: got %0d/%0d expected 3/18", bus.result_count, bus.result_sum); end
        checks++; if (bus.result_max !== 32'd9 || bus.result_min !== 32'd2) begin errors++; $display("FAIL fresh_maxmin: got %0d/%0d expected 9/2", bus.result_max, bus.result_min); end
        ack_result();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.EN_reduce    = 1'b0;
        bus.VALID_memVal = 1'b0;
        bus.memVal_data  = '0;
        bus.EN_resultAck = 1'b0;
        test_reset();
        test_stream_63();
        test_hold_ack();
        test_max_count();
        test_timeout();
        test_timeout_edge();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
